uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver for the challenge design's `uart` pad input. It synchronises the asynchronous line, frames 8N1 characters by mid-bit sampling, and presents each received byte on a single-entry valid/ready output register. The password/LED checker stage downstream consumes that register. Framing errors and overruns are reported as one-cycle pulses.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 87: clock cycles per bit (10 MHz / 115200 baud). Legal values are ≥ 4.
- `HALF_BIT`, default `CLKS_PER_BIT/2` (integer division): cycles from start-bit detection to the start-bit sample.

Ports:
- `clk_10`  in  1: system clock, 10 MHz; all logic rises on this edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `uart`  in  1: raw serial line, asynchronous, idle high.
- `rx_data`  out  8: received byte, LSB-first on the wire.
- `rx_valid`  out  1: `rx_data` holds an unconsumed byte.
- `rx_ready`  in  1: consumer accepts the byte in any cycle where `rx_valid && rx_ready`.
- `frame_err`  out  1: one-cycle pulse when a stop bit is sampled low.
- `overrun`  out  1: one-cycle pulse when a completed byte is dropped because the holding register is full.

## Operation
- **Synchroniser:** `uart` passes through two flops (`rx_sync`). Both reset to 1. The FSM only ever reads `rx_sync`.
- **Bit counter:** width `$clog2(CLKS_PER_BIT)`, cleared on every state change. The data-bit counter is 3 bits.
- **State machine:**
  - IDLE: when `rx_sync == 0`, go to START with the counter at 0.
  - START: count 0..`HALF_BIT-1`, then sample. If the sample is 0, go to DATA. If it is 1, this is a glitch: return to IDLE with no error flagged.
  - DATA: count 0..`CLKS_PER_BIT-1`, then sample into the shift register, LSB first. After the 8th bit, go to STOP.
  - STOP: count 0..`CLKS_PER_BIT-1`, then sample.
    - Sample 1: the byte is complete; hand it off per the holding-register rules. Go to IDLE.
    - Sample 0: pulse `frame_err`, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_sync == 1`, then go to IDLE. This prevents a break condition from retriggering reception.
- **Holding register:**
  - A completed byte loads `rx_data` and sets `rx_valid` if `rx_valid == 0`, or if `rx_valid && rx_ready` in the same cycle.
  - In the simultaneous case the new byte replaces the old one, `rx_valid` stays 1, and no overrun is flagged.
  - Otherwise the new byte is dropped, `overrun` pulses, and `rx_data` and `rx_valid` are unchanged.
- `rx_valid` clears on `rx_valid && rx_ready` when no new byte is completing in that cycle.
- `rx_data` is stable whenever `rx_valid == 1`, except at the simultaneous replace described above.
- Reception continues regardless of `rx_ready`; the receiver never stalls.

## Timing
- Reset values:
  - `rx_data` = 0x00; `rx_valid`, `frame_err`, `overrun` = 0.
  - FSM in IDLE; counters at 0; `rx_sync` = 1.
- Reset mid-frame aborts the frame: nothing is output and no error is flagged. Reception restarts at the next falling edge after reset releases.
- Synchroniser latency is 2 cycles from the `uart` pin to `rx_sync`.
- Sample instants, with t0 = the IDLE cycle that first sees `rx_sync == 0`:
  - Start bit sampled at t0 + `HALF_BIT`.
  - Data bit i (0..7) sampled at t0 + `HALF_BIT` + (i+1)·`CLKS_PER_BIT`.
  - Stop bit sampled at t0 + `HALF_BIT` + 9·`CLKS_PER_BIT`.
- Outputs after the stop sample:
  - `rx_valid` rises, or `frame_err`/`overrun` pulses, on the edge following the stop sample.
  - With defaults this is t0 + 827.
- The FSM is back in IDLE one cycle after the stop sample, so back-to-back frames with zero inter-frame gap are received.
- `frame_err` and `overrun` are registered outputs, each exactly one cycle wide.

## Test plan
- **Basic byte:** send 0xA5 at default `CLKS_PER_BIT`, with `rx_ready` = 0.
  - `rx_valid` rises 827 cycles after t0, with `rx_data` = 0xA5.
  - It stays high until `rx_ready` is pulsed, then `rx_valid` = 0 on the next cycle.
- **Glitch rejection:** drive `uart` low for 20 cycles, then high.
  - `rx_valid`, `frame_err` and `overrun` all remain 0.
  - FSM returns to IDLE.
  - A following 0x3C is received correctly.
- **Framing error:** send 0x55 with the stop bit held low for 3 bit times, then high.
  - Exactly one `frame_err` pulse; no `rx_valid`.
  - A subsequent 0x12 is received correctly.
- **Overrun:** send 0x11 then 0x22 back-to-back with `rx_ready` = 0.
  - One `overrun` pulse at the end of the second frame.
  - `rx_data` stays 0x11 and `rx_valid` stays 1.
- **Streaming:** hold `rx_ready` = 1 and send 0x00, 0xFF, 0x81 with zero gap.
  - Three single-cycle `rx_valid` pulses carrying 0x00, 0xFF, 0x81.
  - No `overrun`, no `frame_err`.
- **Reset mid-frame:** assert `rst_n` = 0 during data bit 4 of a frame.
  - All outputs go to reset values immediately.
  - After release and the line going idle, a new 0xC3 is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 serial receiver: two-flop synchroniser, mid-bit sampling FSM and a
// single-entry valid/ready holding register with framing/overrun pulses.
module uart_rx #(
    parameter int CLKS_PER_BIT = 87,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk_10,
    input  logic       rst_n,
    input  logic       uart,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
    logic          rx_sync;
    logic          byte_done;

    // The FSM only looks at the second synchroniser stage.
    assign rx_sync = sync_q[1];
    assign sync_d  = {sync_q[0], uart};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CW'(1);
        bit_d       = bit_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        byte_done   = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_sync) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    // A start bit that has gone high again by mid-bit is a glitch.
                    state_d = rx_sync ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_sync) begin
                        byte_done = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_sync) state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Holding register: a completing byte may replace one being consumed
    // in the same cycle; otherwise a full register drops it.
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = 1'b0;
        if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
        if (byte_done) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_10 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sync_q      <= 2'b11;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at default baud: latency, glitch, framing,
// overrun, streaming and mid-frame reset.
module tb_uart_rx;

    localparam int CPB     = 87;
    localparam int LATENCY = 2 + CPB / 2 + 9 * CPB + 1;  // pin edge to rx_valid

    logic       clk_10 = 1'b0;
    logic       rst_n;
    logic       uart;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int last_start = 0;

    int         rises = 0;
    int         vhigh = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         last_rise = 0;
    int         got_n = 0;
    logic [7:0] got_data [64];
    logic       v_prev = 1'b0;

    uart_rx dut (
        .clk_10   (clk_10),
        .rst_n    (rst_n),
        .uart     (uart),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #50 clk_10 = ~clk_10;

    always @(posedge clk_10) cyc <= cyc + 1;

    always @(negedge clk_10) begin
        if (rst_n) begin
            if (rx_valid && !v_prev) begin
                rises     <= rises + 1;
                last_rise <= cyc;
                if (got_n < 64) got_data[got_n] <= rx_data;
                got_n <= got_n + 1;
            end
            if (rx_valid) vhigh <= vhigh + 1;
            fe_cnt <= fe_cnt + int'(frame_err);
            ov_cnt <= ov_cnt + int'(overrun);
        end
        v_prev <= rx_valid;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Caller must be just after a posedge; returns just after a posedge.
    task automatic send_frame(input logic [7:0] b, input int stop_low);
        #1 uart = 1'b0;
        last_start = cyc;
        repeat (CPB) @(posedge clk_10);
        for (int i = 0; i < 8; i++) begin
            #1 uart = b[i];
            repeat (CPB) @(posedge clk_10);
        end
        if (stop_low > 0) begin
            #1 uart = 1'b0;
            repeat (CPB * stop_low) @(posedge clk_10);
        end
        #1 uart = 1'b1;
        repeat (CPB) @(posedge clk_10);
    endtask

    task automatic consume();
        @(posedge clk_10);
        #1 rx_ready = 1'b1;
        @(posedge clk_10);
        #1 rx_ready = 1'b0;
        @(negedge clk_10);
    endtask

    int r0, h0, f0, o0, g0;
    logic [7:0] b4;

    task automatic snap();
        r0 = rises; h0 = vhigh; f0 = fe_cnt; o0 = ov_cnt; g0 = got_n;
    endtask

    initial begin
        rst_n    = 1'b0;
        uart     = 1'b1;
        rx_ready = 1'b0;
        repeat (5) @(posedge clk_10);
        @(negedge clk_10);
        chk("reset_valid", rx_valid, 0);
        chk("reset_data", rx_data, 8'h00);
        chk("reset_ferr", frame_err, 0);
        chk("reset_ovr", overrun, 0);
        @(posedge clk_10);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk_10);

        // Basic byte, consumer not ready
        snap();
        send_frame(8'hA5, 0);
        repeat (30) @(posedge clk_10);
        @(negedge clk_10);
        chk("basic_latency", last_rise - last_start, LATENCY);
        chk("basic_data", rx_data, 8'hA5);
        chk("basic_hold_valid", rx_valid, 1);
        chk("basic_rises", rises - r0, 1);
        consume();
        chk("basic_cleared", rx_valid, 0);

        // Glitch shorter than half a bit
        snap();
        @(posedge clk_10);
        #1 uart = 1'b0;
        repeat (20) @(posedge clk_10);
        #1 uart = 1'b1;
        repeat (200) @(posedge clk_10);
        @(negedge clk_10);
        chk("glitch_valid", rx_valid, 0);
        chk("glitch_rises", rises - r0, 0);
        chk("glitch_ferr", fe_cnt - f0, 0);
        chk("glitch_ovr", ov_cnt - o0, 0);
        @(posedge clk_10);
        send_frame(8'h3C, 0);
        @(negedge clk_10);
        chk("glitch_next_data", rx_data, 8'h3C);
        chk("glitch_next_valid", rx_valid, 1);
        consume();

        // Framing error: stop bit low for three bit times
        snap();
        @(posedge clk_10);
        send_frame(8'h55, 3);
        repeat (20) @(posedge clk_10);
        @(negedge clk_10);
        chk("ferr_pulses", fe_cnt - f0, 1);
        chk("ferr_no_valid", rises - r0, 0);
        chk("ferr_valid", rx_valid, 0);
        @(posedge clk_10);
        send_frame(8'h12, 0);
        @(negedge clk_10);
        chk("ferr_next_data", rx_data, 8'h12);
        chk("ferr_next_valid", rx_valid, 1);
        consume();

        // Overrun: two back-to-back frames, never consumed
        snap();
        @(posedge clk_10);
        send_frame(8'h11, 0);
        send_frame(8'h22, 0);
        repeat (10) @(posedge clk_10);
        @(negedge clk_10);
        chk("ovr_pulses", ov_cnt - o0, 1);
        chk("ovr_data", rx_data, 8'h11);
        chk("ovr_valid", rx_valid, 1);
        chk("ovr_ferr", fe_cnt - f0, 0);
        consume();

        // Streaming with consumer always ready
        snap();
        @(posedge clk_10);
        #1 rx_ready = 1'b1;
        send_frame(8'h00, 0);
        send_frame(8'hFF, 0);
        send_frame(8'h81, 0);
        repeat (10) @(posedge clk_10);
        @(negedge clk_10);
        chk("stream_rises", rises - r0, 3);
        chk("stream_high_cycles", vhigh - h0, 3);
        chk("stream_b0", got_data[g0], 8'h00);
        chk("stream_b1", got_data[g0+1], 8'hFF);
        chk("stream_b2", got_data[g0+2], 8'h81);
        chk("stream_ovr", ov_cnt - o0, 0);
        chk("stream_ferr", fe_cnt - f0, 0);
        chk("stream_valid_low", rx_valid, 0);
        @(posedge clk_10);
        #1 rx_ready = 1'b0;

        // Reset during data bit 4, with a byte already held
        @(posedge clk_10);
        send_frame(8'h5A, 0);
        @(negedge clk_10);
        chk("rst_pre_valid", rx_valid, 1);
        b4 = 8'hF0;
        #1 uart = 1'b0;
        repeat (CPB) @(posedge clk_10);
        for (int i = 0; i < 5; i++) begin
            #1 uart = b4[i];
            repeat ((i == 4) ? 40 : CPB) @(posedge clk_10);
        end
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", rx_valid, 0);
        chk("rst_mid_data", rx_data, 8'h00);
        chk("rst_mid_ferr", frame_err, 0);
        chk("rst_mid_ovr", overrun, 0);
        uart = 1'b1;
        repeat (10) @(posedge clk_10);
        #1 rst_n = 1'b1;
        snap();
        repeat (1000) @(posedge clk_10);
        @(negedge clk_10);
        chk("rst_after_rises", rises - r0, 0);
        chk("rst_after_ferr", fe_cnt - f0, 0);
        chk("rst_after_ovr", ov_cnt - o0, 0);
        @(posedge clk_10);
        send_frame(8'hC3, 0);
        @(negedge clk_10);
        chk("rst_next_data", rx_data, 8'hC3);
        chk("rst_next_valid", rx_valid, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
